// File: rtl/anton_neopixel_stream_sequencer_pkg.sv
// Shared types and defaults for the NeoPixel frame sequencer.
package anton_neopixel_stream_sequencer_pkg;

    localparam int BUFFER_END_DEFAULT   = 8191;
    localparam int LATCH_CYCLES_DEFAULT = 2000;
    localparam int INIT_CYCLES_DEFAULT  = 4000;

    typedef enum logic [2:0] {
        NEOSEQ_IDLE    = 3'd0,
        NEOSEQ_FETCH   = 3'd1,
        NEOSEQ_PRESENT = 3'd2,
        NEOSEQ_LATCH   = 3'd3,
        NEOSEQ_SYNC    = 3'd4,
        NEOSEQ_INIT    = 3'd5
    } neoSeqState_e;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/anton_neopixel_delay_counter.sv
// Loadable down-counter; done is high while the count sits at zero.
module anton_neopixel_delay_counter #(
    parameter int WIDTH = 12
) (
    input  logic             busClk,
    input  logic             busRstN,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    input  logic             count,
    output logic             done
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge busClk or negedge busRstN) begin
        if (!busRstN)
            cnt <= '0;
        else if (load)
            cnt <= loadVal;
        else if (count && cnt != '0)
            cnt <= cnt - WIDTH'(1);
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/anton_neopixel_stream_sequencer.sv
// Walks the frame buffer, hands bytes to the serializer, then latches the line
// and pulses end-of-frame; also times slow-init requests.
module anton_neopixel_stream_sequencer
    import anton_neopixel_stream_sequencer_pkg::*;
#(
    parameter  int BUFFER_END   = BUFFER_END_DEFAULT,
    parameter  int LATCH_CYCLES = LATCH_CYCLES_DEFAULT,
    parameter  int INIT_CYCLES  = INIT_CYCLES_DEFAULT,
    localparam int BUFFER_BITS  = $clog2(BUFFER_END + 1)
) (
    input  logic                   busClk,
    input  logic                   busRstN,
    input  logic [12:0]            regMax,
    input  logic                   regCtrlRun,
    input  logic                   regCtrlLimit,
    input  logic                   regCtrl32bit,
    input  logic                   initSlow,
    output logic [BUFFER_BITS-1:0] pixelIndexComb,
    input  logic [7:0]             pixelByte,
    output logic [7:0]             byteData,
    output logic                   byteValid,
    input  logic                   byteReady,
    output logic                   state,
    output logic                   streamSyncOf,
    output logic                   initSlowDone
);

    localparam int IW = BUFFER_BITS;
    localparam int CW = $clog2(maxInt(LATCH_CYCLES, INIT_CYCLES) + 1);

    neoSeqState_e    curState, nextState;
    logic [IW-1:0]   idxQ, nextIdx, endIdxQ, endIdxComb;
    logic            is32Q;
    logic [IW:0]     nxtSend;
    logic [31:0]     regMaxW;
    logic            cntLoad, cntEn, cntDone, capture, sample;
    logic [CW-1:0]   cntVal;

    assign regMaxW    = {19'd0, regMax};
    assign endIdxComb = (!regCtrlLimit || regMaxW > 32'(BUFFER_END)) ? IW'(BUFFER_END)
                                                                     : IW'(regMaxW);

    // Next sendable index, one bit wider so running past the end never wraps.
    always_comb begin
        nxtSend = {1'b0, idxQ} + (IW+1)'(1);
        if (!is32Q && nxtSend[1:0] == 2'b11)
            nxtSend = nxtSend + (IW+1)'(1);
    end

    always_comb begin
        nextState = curState;
        nextIdx   = idxQ;
        cntLoad   = 1'b0;
        cntVal    = '0;
        cntEn     = 1'b0;
        capture   = 1'b0;
        sample    = 1'b0;
        case (curState)
            NEOSEQ_IDLE: if (regCtrlRun) begin
                nextState = NEOSEQ_FETCH;
                nextIdx   = '0;
                sample    = 1'b1;
            end
            NEOSEQ_FETCH: begin
                nextState = NEOSEQ_PRESENT;
                capture   = 1'b1;
            end
            NEOSEQ_PRESENT: if (byteReady) begin
                if (nxtSend > {1'b0, endIdxQ}) begin
                    nextState = NEOSEQ_LATCH;
                    cntLoad   = 1'b1;
                    cntVal    = CW'(LATCH_CYCLES - 1);
                end else begin
                    nextState = NEOSEQ_FETCH;
                    nextIdx   = nxtSend[IW-1:0];
                end
            end
            NEOSEQ_LATCH: if (cntDone) nextState = NEOSEQ_SYNC;
                          else         cntEn     = 1'b1;
            NEOSEQ_SYNC:  nextState = NEOSEQ_IDLE;
            NEOSEQ_INIT:  if (cntDone) nextState = NEOSEQ_IDLE;
                          else         cntEn     = 1'b1;
            default:      nextState = NEOSEQ_IDLE;
        endcase
        // A held request must not restart INIT, otherwise it could never finish.
        if (initSlow && curState != NEOSEQ_INIT) begin
            nextState = NEOSEQ_INIT;
            nextIdx   = '0;
            cntLoad   = 1'b1;
            cntVal    = CW'(INIT_CYCLES - 1);
            capture   = 1'b0;
            sample    = 1'b0;
        end
    end

    always_ff @(posedge busClk or negedge busRstN) begin
        if (!busRstN) begin
            curState <= NEOSEQ_IDLE;
            idxQ     <= '0;
            endIdxQ  <= '0;
            is32Q    <= 1'b0;
            byteData <= '0;
        end else begin
            curState <= nextState;
            idxQ     <= nextIdx;
            if (sample) begin
                endIdxQ <= endIdxComb;
                is32Q   <= regCtrl32bit;
            end
            if (capture)
                byteData <= pixelByte;
        end
    end

    anton_neopixel_delay_counter #(.WIDTH(CW)) uDelay (
        .busClk  (busClk),
        .busRstN (busRstN),
        .load    (cntLoad),
        .loadVal (cntVal),
        .count   (cntEn),
        .done    (cntDone)
    );

    // Address leads the state by one clock so the registered RAM read lands in FETCH.
    assign pixelIndexComb = nextIdx;
    assign byteValid      = (curState == NEOSEQ_PRESENT);
    assign state          = (curState == NEOSEQ_FETCH) || (curState == NEOSEQ_PRESENT) ||
                            (curState == NEOSEQ_LATCH);
    assign streamSyncOf   = (curState == NEOSEQ_SYNC);
    assign initSlowDone   = (curState == NEOSEQ_INIT) && cntDone;

endmodule

// File: tb/tb_anton_neopixel_stream_sequencer.sv
// Directed bench for the frame sequencer with a registered-read RAM model.
module tb_anton_neopixel_stream_sequencer;

    localparam int BE = 15;
    localparam int LC = 20;
    localparam int IC = 30;

    logic        busClk = 1'b0;
    logic        busRstN = 1'b0;
    logic [12:0] regMax = '0;
    logic        regCtrlRun = 1'b0, regCtrlLimit = 1'b0, regCtrl32bit = 1'b0;
    logic        initSlow = 1'b0, byteReady = 1'b0;
    logic [3:0]  pixelIndexComb;
    logic [7:0]  pixelByte = '0, byteData;
    logic        byteValid, state, streamSyncOf, initSlowDone;
    logic [7:0]  mem [0:BE];
    logic        watchIdx = 1'b0;
    int          badIdx = 0;
    int          nChk = 0, nPass = 0;

    always #5 busClk = ~busClk;

    always @(posedge busClk) pixelByte <= mem[pixelIndexComb];

    always @(negedge busClk)
        if (watchIdx && (pixelIndexComb == 4'd3 || pixelIndexComb == 4'd7)) badIdx++;

    anton_neopixel_stream_sequencer #(
        .BUFFER_END(BE), .LATCH_CYCLES(LC), .INIT_CYCLES(IC)
    ) dut (
        .busClk         (busClk),
        .busRstN        (busRstN),
        .regMax         (regMax),
        .regCtrlRun     (regCtrlRun),
        .regCtrlLimit   (regCtrlLimit),
        .regCtrl32bit   (regCtrl32bit),
        .initSlow       (initSlow),
        .pixelIndexComb (pixelIndexComb),
        .pixelByte      (pixelByte),
        .byteData       (byteData),
        .byteValid      (byteValid),
        .byteReady      (byteReady),
        .state          (state),
        .streamSyncOf   (streamSyncOf),
        .initSlowDone   (initSlowDone)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        nChk++;
        if (obs == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Pulse (or hold) run from IDLE and check the FETCH cycle.
    task automatic startRun(input string tag, input logic hold);
        @(negedge busClk); regCtrlRun = 1'b1;
        @(negedge busClk);
        chk({tag, " fetch state"}, int'(state), 1);
        chk({tag, " fetch valid"}, int'(byteValid), 0);
        chk({tag, " fetch idx"}, int'(pixelIndexComb), 0);
        regCtrlRun = hold;
    endtask

    // Collect accepted bytes until the end-of-frame pulse; returns at the sync clock.
    task automatic collect(input string tag, input int expIdx[$]);
        int got[$];
        int lastAcc = 0, syncAt = -1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge busClk);
            if (byteValid && byteReady) begin
                got.push_back(int'(byteData));
                lastAcc = cyc;
            end
            if (streamSyncOf) begin
                syncAt = cyc;
                break;
            end
        end
        if (syncAt < 0) chk({tag, " sync timeout"}, 0, 1);
        chk({tag, " byte count"}, got.size(), expIdx.size());
        for (int i = 0; i < expIdx.size() && i < got.size(); i++)
            chk($sformatf("%s byte%0d", tag, i), got[i], 8'h40 + expIdx[i]);
        if (syncAt >= 0) chk({tag, " latch gap"}, syncAt - lastAcc, LC + 1);
    endtask

    task automatic waitInitDone(input string tag, input int expLen);
        int k = 1;
        while (!initSlowDone && k < IC + 5) begin
            @(negedge busClk); k++;
        end
        chk({tag, " init len"}, k, expLen);
    endtask

    initial begin
        int q[$];
        for (int i = 0; i <= BE; i++) mem[i] = 8'h40 + 8'(i);

        // reset state
        repeat (2) @(negedge busClk);
        chk("rst state", int'(state), 0);
        chk("rst valid", int'(byteValid), 0);
        chk("rst data", int'(byteData), 0);
        chk("rst sync", int'(streamSyncOf), 0);
        chk("rst done", int'(initSlowDone), 0);
        chk("rst idx", int'(pixelIndexComb), 0);
        busRstN = 1'b1;

        // 1: 32-bit, limit at 5
        regCtrlLimit = 1'b1; regMax = 13'd5; regCtrl32bit = 1'b1; byteReady = 1'b1;
        startRun("t1", 1'b0);
        q = {0, 1, 2, 3, 4, 5};
        collect("t1", q);
        @(negedge busClk);
        chk("t1 sync width", int'(streamSyncOf), 0);
        chk("t1 idle", int'(state), 0);

        // 2: 24-bit skips every fourth slot, ending on a skipped slot
        regMax = 13'd7; regCtrl32bit = 1'b0; watchIdx = 1'b1;
        startRun("t2", 1'b0);
        q = {0, 1, 2, 4, 5, 6};
        collect("t2", q);
        @(negedge busClk);
        watchIdx = 1'b0;
        chk("t2 skipped idx seen", badIdx, 0);

        // boundaries: one byte, clamp, and unlimited
        regMax = 13'd0; regCtrl32bit = 1'b1;
        startRun("b0", 1'b0);
        q = {0};
        collect("b0", q);
        regMax = 13'd100;
        startRun("bclamp", 1'b0);
        q = {};
        for (int i = 0; i <= BE; i++) q.push_back(i);
        collect("bclamp", q);
        regCtrlLimit = 1'b0; regMax = 13'd2;
        startRun("bnolim", 1'b0);
        collect("bnolim", q);
        regCtrlLimit = 1'b1;

        // 3: loop with run held, then run dropped mid-frame
        regMax = 13'd2;
        startRun("t3a", 1'b1);
        q = {0, 1, 2};
        collect("t3a", q);
        @(negedge busClk);
        chk("t3 idle between", int'(state), 0);
        @(negedge busClk);
        chk("t3 refetch", int'(state), 1);
        chk("t3 refetch valid", int'(byteValid), 0);
        regCtrlRun = 1'b0;
        collect("t3b", q);
        repeat (3) @(negedge busClk);
        chk("t3 stays idle", int'(state), 0);

        // 4: backpressure holds the byte and the index
        regMax = 13'd3; byteReady = 1'b0;
        startRun("t4", 1'b0);
        begin
            int stable = 1;
            for (int i = 0; i < 10; i++) begin
                @(negedge busClk);
                if (!byteValid || byteData != 8'h40 || pixelIndexComb != 4'd0) stable = 0;
            end
            chk("t4 stable under stall", stable, 1);
        end
        byteReady = 1'b1;
        q = {1, 2, 3};
        collect("t4", q);

        // 5: slow init mid-frame at byte 2
        regMax = 13'd7;
        startRun("t5", 1'b0);
        repeat (4) @(negedge busClk);
        @(negedge busClk);
        chk("t5 byte2 valid", int'(byteValid), 1);
        chk("t5 byte2 data", int'(byteData), 8'h42);
        initSlow = 1'b1;
        @(negedge busClk);
        chk("t5 valid drop", int'(byteValid), 0);
        chk("t5 init state", int'(state), 0);
        initSlow = 1'b0;
        waitInitDone("t5", IC);
        @(negedge busClk);
        chk("t5 done width", int'(initSlowDone), 0);
        regMax = 13'd1;
        startRun("t5r", 1'b0);
        q = {0, 1};
        collect("t5r", q);

        // init wins over a simultaneous run
        @(negedge busClk);
        initSlow = 1'b1; regCtrlRun = 1'b1;
        @(negedge busClk);
        chk("tw not fetch", int'(state), 0);
        initSlow = 1'b0; regCtrlRun = 1'b0;
        waitInitDone("tw", IC);

        // 6: async reset mid-PRESENT
        regMax = 13'd5; byteReady = 1'b0;
        startRun("t6", 1'b0);
        @(negedge busClk);
        chk("t6 presenting", int'(byteValid), 1);
        #2 busRstN = 1'b0;
        #1;
        chk("t6 async valid", int'(byteValid), 0);
        chk("t6 async data", int'(byteData), 0);
        chk("t6 async state", int'(state), 0);
        @(negedge busClk);
        busRstN = 1'b1; byteReady = 1'b1; regMax = 13'd1;
        startRun("t6r", 1'b0);
        q = {0, 1};
        collect("t6r", q);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
